// File: rtl/fft_frame_pkg.sv
// Shared definitions for the FFT frame loader.
//   state_e : loader FSM states
//   clog2   : ceiling log2, for deriving address widths
//   bitrev  : reverse the low 'width' bits of a value (DIT input ordering)
package fft_frame_pkg;

  typedef enum logic [1:0] {
    LOAD_RE = 2'd0,
    LOAD_IM = 2'd1,
    START   = 2'd2,
    WAIT    = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) r[5'(width - 1 - i)] = value[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_timer.sv
// Inter-byte timeout counter for the frame loader.
//   clk, rst : clock, asynchronous active-high reset
//   en       : timer runs while a frame is partially loaded
//   clr      : restart the count (a byte arrived)
//   expire   : high in the cycle whose clock edge would be the TIMEOUT-th idle clock
module fft_frame_timer #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // A byte in the same cycle always beats expiry.
  assign expire = en && !clr && (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || clr || expire) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Loads interleaved (re, im) bytes from the UART into the FFT sample buffer,
// starts the FFT once N samples are written, and waits for fft_done.
//   rx_valid/rx_data   : incoming byte strobe and data
//   fft_done           : transform-complete strobe
//   ovr_clr            : clears the sticky overrun flag
//   wr_en/addr/re/im   : sample buffer write port (natural or bit-reversed address)
//   fft_start, busy    : FFT launch pulse and in-progress flag
//   frame_err          : pulse when a partial frame is abandoned on timeout
//   overrun            : sticky, a byte arrived while the FFT owned the buffer
//   sample_cnt         : samples written in the current frame (reaches N)
module fft_frame_loader
  import fft_frame_pkg::*;
#(
  parameter int unsigned N       = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned BITREV  = 0,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              fft_done,
  input  logic              ovr_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_re,
  output logic [DATA_W-1:0] wr_im,
  output logic              fft_start,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic [ADDR_W:0]   sample_cnt
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   re_hold_q, re_hold_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_re_q, wr_re_d;
  logic [DATA_W-1:0]   wr_im_q, wr_im_d;
  logic                fft_start_q, fft_start_d;
  logic                busy_q, busy_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic [ADDR_W:0]     sample_cnt_q, sample_cnt_d;

  logic                ovr_set;
  logic                tmr_en;
  logic                tmr_expire;
  logic [ADDR_W-1:0]   cnt;
  logic                last_sample;

  // The low bits of sample_cnt are the in-frame sample index; the extra MSB
  // only becomes set once the frame is complete.
  assign cnt         = sample_cnt_q[ADDR_W-1:0];
  assign last_sample = (sample_cnt_q == (ADDR_W+1)'(N - 1));
  assign tmr_en      = (state_q == LOAD_IM) ||
                       ((state_q == LOAD_RE) && (sample_cnt_q != '0));

  fft_frame_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (tmr_en),
    .clr    (rx_valid),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    re_hold_d    = re_hold_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_re_d      = wr_re_q;
    wr_im_d      = wr_im_q;
    fft_start_d  = 1'b0;
    busy_d       = busy_q;
    frame_err_d  = 1'b0;
    sample_cnt_d = sample_cnt_q;
    ovr_set      = 1'b0;

    case (state_q)
      LOAD_RE: begin
        if (rx_valid) begin
          re_hold_d = rx_data;
          state_d   = LOAD_IM;
        end else if (tmr_expire) begin
          frame_err_d  = 1'b1;
          sample_cnt_d = '0;
        end
      end
      LOAD_IM: begin
        if (rx_valid) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = (BITREV != 0) ? ADDR_W'(bitrev(32'(cnt), ADDR_W)) : cnt;
          wr_re_d      = re_hold_q;
          wr_im_d      = rx_data;
          sample_cnt_d = sample_cnt_q + 1'b1;
          state_d      = last_sample ? START : LOAD_RE;
        end else if (tmr_expire) begin
          frame_err_d  = 1'b1;
          sample_cnt_d = '0;
          re_hold_d    = '0;
          state_d      = LOAD_RE;
        end
      end
      START: begin
        fft_start_d = 1'b1;
        busy_d      = 1'b1;
        state_d     = WAIT;
        // The buffer already belongs to the FFT here, so a byte is an overrun.
        ovr_set     = rx_valid;
      end
      WAIT: begin
        ovr_set = rx_valid;
        if (fft_done) begin
          sample_cnt_d = '0;
          busy_d       = 1'b0;
          state_d      = LOAD_RE;
        end
      end
      default: state_d = LOAD_RE;
    endcase

    overrun_d = ovr_set | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD_RE;
      re_hold_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_re_q      <= '0;
      wr_im_q      <= '0;
      fft_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      re_hold_q    <= re_hold_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_re_q      <= wr_re_d;
      wr_im_q      <= wr_im_d;
      fft_start_q  <= fft_start_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_re      = wr_re_q;
  assign wr_im      = wr_im_q;
  assign fft_start  = fft_start_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: a natural-order and a bit-reversed
// instance share the same input stream; writes, starts and frame errors are
// collected by a monitor and compared with the expected frame layout.
module tb_fft_frame_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       fft_done;
  logic       ovr_clr;

  logic       wr_en, fft_start, busy, frame_err, overrun;
  logic [2:0] wr_addr;
  logic [7:0] wr_re, wr_im;
  logic [3:0] sample_cnt;

  logic       br_wr_en, br_fft_start, br_busy, br_frame_err, br_overrun;
  logic [2:0] br_wr_addr;
  logic [7:0] br_wr_re, br_wr_im;
  logic [3:0] br_sample_cnt;

  logic [27:0] outs, br_outs;
  assign outs    = {wr_en, wr_addr, wr_re, wr_im, fft_start, busy, frame_err, overrun, sample_cnt};
  assign br_outs = {br_wr_en, br_wr_addr, br_wr_re, br_wr_im, br_fft_start, br_busy,
                    br_frame_err, br_overrun, br_sample_cnt};

  fft_frame_loader #(.N(8), .ADDR_W(3), .DATA_W(8), .BITREV(0), .TIMEOUT(50), .TO_W(6)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .fft_done(fft_done),
    .ovr_clr(ovr_clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im),
    .fft_start(fft_start), .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .sample_cnt(sample_cnt));

  fft_frame_loader #(.N(8), .ADDR_W(3), .DATA_W(8), .BITREV(1), .TIMEOUT(50), .TO_W(6)) dut_br (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .fft_done(fft_done),
    .ovr_clr(ovr_clr), .wr_en(br_wr_en), .wr_addr(br_wr_addr), .wr_re(br_wr_re),
    .wr_im(br_wr_im), .fft_start(br_fft_start), .busy(br_busy), .frame_err(br_frame_err),
    .overrun(br_overrun), .sample_cnt(br_sample_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [7:0]  re;
    logic [7:0]  im;
    int unsigned cyc;
  } wr_t;

  wr_t         wr_q[$];
  wr_t         br_q[$];
  int unsigned start_q[$];
  int unsigned br_start_q[$];
  int unsigned ferr_q[$];
  int unsigned br_ferr_q[$];
  int unsigned cyc = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_b [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en)        wr_q.push_back('{wr_addr, wr_re, wr_im, cyc});
    if (br_wr_en)     br_q.push_back('{br_wr_addr, br_wr_re, br_wr_im, cyc});
    if (fft_start)    start_q.push_back(cyc);
    if (br_fft_start) br_start_q.push_back(cyc);
    if (frame_err)    ferr_q.push_back(cyc);
    if (br_frame_err) br_ferr_q.push_back(cyc);
  end

  // Bit-reversed index of a 3-bit sample number.
  function automatic int unsigned rev3(input int unsigned k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    br_q.delete();
    start_q.delete();
    br_start_q.delete();
    ferr_q.delete();
    br_ferr_q.delete();
  endtask

  task automatic load_frame(input bit fixed, input int unsigned mingap, input int unsigned maxgap);
    for (int i = 0; i < 16; i++) frame_b[i] = fixed ? 8'(i + 1) : 8'($urandom);
    for (int i = 0; i < 16; i++)
      send_byte(frame_b[i], (i == 15) ? 0 : $urandom_range(maxgap, mingap));
    repeat (3) tick();
  endtask

  // Compares everything collected since clear_mon against one complete frame
  // built from frame_b.
  task automatic check_frame(input string tag);
    checks++;
    if (wr_q.size() != 8 || br_q.size() != 8) begin
      errors++;
      $display("FAIL %s write_count: got %0d/%0d, expected 8/8", tag, wr_q.size(), br_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (wr_q[k].addr !== 3'(k) || wr_q[k].re !== frame_b[2*k] || wr_q[k].im !== frame_b[2*k+1]) begin
          errors++;
          $display("FAIL %s write%0d: got addr=%0d re=%h im=%h, expected addr=%0d re=%h im=%h", tag, k,
                   wr_q[k].addr, wr_q[k].re, wr_q[k].im, k, frame_b[2*k], frame_b[2*k+1]);
        end
        checks++;
        if (br_q[k].addr !== 3'(rev3(k)) || br_q[k].re !== frame_b[2*k] || br_q[k].im !== frame_b[2*k+1]) begin
          errors++;
          $display("FAIL %s bitrev_write%0d: got addr=%0d re=%h im=%h, expected addr=%0d re=%h im=%h", tag, k,
                   br_q[k].addr, br_q[k].re, br_q[k].im, rev3(k), frame_b[2*k], frame_b[2*k+1]);
        end
      end
      checks++;
      if (start_q.size() != 1 || start_q[0] != wr_q[7].cyc + 1) begin
        errors++;
        $display("FAIL %s fft_start: got %0d pulses first at cyc %0d, expected 1 pulse at cyc %0d", tag,
                 start_q.size(), (start_q.size() > 0) ? start_q[0] : 0, wr_q[7].cyc + 1);
      end
      checks++;
      if (br_start_q.size() != 1 || br_start_q[0] != br_q[7].cyc + 1) begin
        errors++;
        $display("FAIL %s bitrev_fft_start: got %0d pulses, expected 1 pulse at cyc %0d", tag,
                 br_start_q.size(), br_q[7].cyc + 1);
      end
    end
    checks++;
    if (busy !== 1'b1 || br_busy !== 1'b1 || sample_cnt !== 4'd8 || br_sample_cnt !== 4'd8) begin
      errors++;
      $display("FAIL %s busy_count: got busy=%b/%b cnt=%0d/%0d, expected busy=1/1 cnt=8/8", tag,
               busy, br_busy, sample_cnt, br_sample_cnt);
    end
    checks++;
    if (wr_addr !== 3'd7 || br_wr_addr !== 3'd7 || wr_re !== frame_b[14] || wr_im !== frame_b[15]) begin
      errors++;
      $display("FAIL %s write_hold: got addr=%0d/%0d re=%h im=%h, expected addr=7/7 re=%h im=%h", tag,
               wr_addr, br_wr_addr, wr_re, wr_im, frame_b[14], frame_b[15]);
    end
    checks++;
    if (ferr_q.size() != 0 || br_ferr_q.size() != 0) begin
      errors++;
      $display("FAIL %s frame_err: got %0d/%0d pulses, expected 0", tag, ferr_q.size(), br_ferr_q.size());
    end
  endtask

  task automatic finish_frame(input string tag);
    pulse_done();
    tick();
    checks++;
    if (busy !== 1'b0 || br_busy !== 1'b0 || sample_cnt !== 4'd0) begin
      errors++;
      $display("FAIL %s after_done: got busy=%b/%b cnt=%0d, expected busy=0/0 cnt=0", tag,
               busy, br_busy, sample_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (outs !== '0 || br_outs !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h, expected 0", outs, br_outs);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (outs !== '0 || br_outs !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h/%h, expected 0", outs, br_outs);
    end
  endtask

  task automatic test_natural_and_bitrev();
    clear_mon();
    load_frame(1'b1, 20, 20);
    check_frame("fixed_frame");
    finish_frame("fixed_frame");
    clear_mon();
    load_frame(1'b0, 0, 30);
    check_frame("random_frame");
    finish_frame("random_frame");
  endtask

  task automatic test_timeout();
    clear_mon();
    repeat (100) tick();
    checks++;
    if (ferr_q.size() != 0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_timeout: got %0d pulses, expected 0", ferr_q.size());
    end
    for (int nb = 5; nb >= 4; nb--) begin
      clear_mon();
      for (int i = 0; i < nb; i++) begin
        frame_b[i] = 8'($urandom);
        send_byte(frame_b[i], (i == nb - 1) ? 0 : $urandom_range(10, 0));
      end
      repeat (49) tick();
      checks++;
      if (frame_err !== 1'b0 || br_frame_err !== 1'b0 || sample_cnt !== 4'd2) begin
        errors++;
        $display("FAIL timeout_early_%0d: got err=%b/%b cnt=%0d, expected err=0/0 cnt=2", nb,
                 frame_err, br_frame_err, sample_cnt);
      end
      tick();
      checks++;
      if (frame_err !== 1'b1 || br_frame_err !== 1'b1 || sample_cnt !== 4'd0) begin
        errors++;
        $display("FAIL timeout_pulse_%0d: got err=%b/%b cnt=%0d, expected err=1/1 cnt=0", nb,
                 frame_err, br_frame_err, sample_cnt);
      end
      tick();
      checks++;
      if (frame_err !== 1'b0 || ferr_q.size() != 1) begin
        errors++;
        $display("FAIL timeout_single_%0d: got err=%b pulses=%0d, expected err=0 pulses=1", nb,
                 frame_err, ferr_q.size());
      end
      checks++;
      if (wr_q.size() != 2 || start_q.size() != 0 ||
          wr_q[0].addr !== 3'd0 || wr_q[0].re !== frame_b[0] || wr_q[0].im !== frame_b[1] ||
          wr_q[1].addr !== 3'd1 || wr_q[1].re !== frame_b[2] || wr_q[1].im !== frame_b[3]) begin
        errors++;
        $display("FAIL timeout_partial_%0d: got %0d writes %0d starts, expected 2 writes (0,1) 0 starts",
                 nb, wr_q.size(), start_q.size());
      end
      clear_mon();
      load_frame(1'b0, 0, 40);
      check_frame("after_timeout");
      finish_frame("after_timeout");
    end
    // 49 idle clocks between every byte is the longest gap that must not abort.
    clear_mon();
    load_frame(1'b0, 49, 49);
    check_frame("max_gap_frame");
    finish_frame("max_gap_frame");
  endtask

  task automatic test_overrun();
    clear_mon();
    load_frame(1'b0, 0, 10);
    check_frame("ovr_frame");
    send_byte(8'h7F, 2);
    send_byte(8'h80, 2);
    checks++;
    if (wr_q.size() != 8 || br_q.size() != 8 || overrun !== 1'b1 || br_overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got writes=%0d ovr=%b/%b busy=%b, expected writes=8 ovr=1/1 busy=1",
               wr_q.size(), overrun, br_overrun, busy);
    end
    pulse_done();
    tick();
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0 || sample_cnt !== 4'd0) begin
      errors++;
      $display("FAIL overrun_held: got ovr=%b busy=%b cnt=%0d, expected ovr=1 busy=0 cnt=0",
               overrun, busy, sample_cnt);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0 || br_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b/%b, expected 0/0", overrun, br_overrun);
    end
    clear_mon();
    load_frame(1'b0, 0, 10);
    check_frame("post_ovr_frame");
    ovr_clr = 1'b1;
    send_byte(8'($urandom), 0);
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: got %b, expected 1", overrun);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    fft_done = 1'b1;
    send_byte(8'($urandom), 0);
    fft_done = 1'b0;
    tick();
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0 || sample_cnt !== 4'd0 || wr_q.size() != 8) begin
      errors++;
      $display("FAIL done_with_byte: got ovr=%b busy=%b cnt=%0d writes=%0d, expected ovr=1 busy=0 cnt=0 writes=8",
               overrun, busy, sample_cnt, wr_q.size());
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    clear_mon();
    load_frame(1'b0, 0, 10);
    check_frame("after_dropped_byte");
    finish_frame("after_dropped_byte");
  endtask

  task automatic test_reset_mid();
    clear_mon();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), (i == 5) ? 0 : $urandom_range(5, 0));
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0 || br_outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_frame: got %h/%h, expected 0", outs, br_outs);
    end
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
    load_frame(1'b0, 0, 10);
    check_frame("after_mid_reset");
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0 || br_outs !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: got %h/%h, expected 0", outs, br_outs);
    end
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
    pulse_done();
    repeat (3) tick();
    checks++;
    if (outs !== '0 || start_q.size() != 0) begin
      errors++;
      $display("FAIL stale_done: got outs=%h starts=%0d, expected 0 and 0", outs, start_q.size());
    end
    load_frame(1'b0, 0, 10);
    check_frame("after_stale_done");
    finish_frame("after_stale_done");
  endtask

  task automatic test_ignored_done();
    clear_mon();
    for (int i = 0; i < 16; i++) frame_b[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      send_byte(frame_b[i], (i == 15) ? 0 : $urandom_range(4, 0));
      if (i == 2 || i == 3 || i == 8) pulse_done();
    end
    repeat (3) tick();
    check_frame("ignored_done");
    finish_frame("ignored_done");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      clear_mon();
      load_frame(1'b0, 0, 0);
      check_frame("back_to_back");
      finish_frame("back_to_back");
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    fft_done = 1'b0;
    ovr_clr  = 1'b0;
    test_reset();
    test_natural_and_bitrev();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_ignored_done();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Controller between the UART receiver byte stream and the FFT input sample buffer.
- Pairs incoming bytes as interleaved (real, imag) samples and writes N complex samples into the buffer, in natural or bit-reversed address order.
- Pulses fft_start, then holds off new input until fft_done.
- Guards against stalled frames with an inter-byte timeout and flags bytes that arrive while the FFT is running.

Parameters:
- N, 256, complex samples per frame; power of two, at least 4.
- ADDR_W, 8, log2(N); buffer address width.
- DATA_W, 8, bits per real/imag component; equals the UART byte width.
- BITREV, 0, 1 writes the buffer at bit-reversed addresses (DIT input order); 0 writes natural order.
- TIMEOUT, 1000, idle clocks allowed between bytes inside a frame (ten 100-clock byte times).
- TO_W, 10, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe; rx_data is a valid byte
- rx_data  in  DATA_W  received byte, two's complement
- fft_done  in  1  one-cycle strobe from the FFT core at end of transform
- ovr_clr  in  1  clears the sticky overrun flag
- wr_en  out  1  sample buffer write strobe
- wr_addr  out  ADDR_W  sample buffer write address
- wr_re  out  DATA_W  real component
- wr_im  out  DATA_W  imaginary component
- fft_start  out  1  one-cycle FFT start pulse
- busy  out  1  high from the fft_start cycle until fft_done is accepted
- frame_err  out  1  one-cycle pulse on timeout abort
- overrun  out  1  sticky: a byte arrived while busy
- sample_cnt  out  ADDR_W+1  samples written in the current frame

Behaviour:
- All outputs are registered. Reset drives every output to 0, sample_cnt to 0, state to LOAD_RE and the timer to 0. Reset takes effect immediately, including mid-frame or mid-FFT; the partial frame is discarded.
- States: LOAD_RE, LOAD_IM, START, WAIT.
- LOAD_RE:
  - On rx_valid, latch rx_data into re_hold and go to LOAD_IM.
- LOAD_IM, on rx_valid at cycle t:
  - Cycle t+1: wr_en=1, wr_addr=cnt (or bitrev(cnt) if BITREV), wr_re=re_hold, wr_im=rx_data.
  - sample_cnt increments.
  - Next state is START if cnt was N-1, otherwise LOAD_RE.
- wr_en is high exactly one cycle per sample. wr_addr, wr_re and wr_im hold their values between writes.
- START:
  - fft_start=1 and busy=1 in the cycle after the last wr_en (t+2).
  - Go to WAIT; fft_start is high for exactly one cycle.
- WAIT:
  - busy stays 1.
  - rx_valid sets overrun; the byte is dropped and no write occurs.
  - On fft_done: sample_cnt=0, busy=0 next cycle, go to LOAD_RE.
- fft_done in any other state is ignored.
- fft_done together with rx_valid in WAIT: the byte is dropped and overrun is set.
- overrun clears on ovr_clr. If ovr_clr and a set condition occur in the same cycle, set wins.
- Timeout:
  - The timer is active in LOAD_IM, and in LOAD_RE when sample_cnt is not 0. It counts clocks without rx_valid.
  - Any rx_valid resets the timer to 0. If rx_valid and expiry fall in the same cycle, rx_valid wins.
  - On reaching TIMEOUT: frame_err pulses 1 cycle, sample_cnt=0, state goes to LOAD_RE, the held real byte is discarded, and the timer clears.
  - The timer is idle, and no frame_err is raised, in LOAD_RE with sample_cnt=0 and in START/WAIT.
- Counter widths:
  - cnt wraps only via the explicit transition to START.
  - sample_cnt reaches N at the START cycle, hence the ADDR_W+1 width.

Decomposition:
- Package fft_frame_pkg holds:
  - state encoding constants (LOAD_RE=0, LOAD_IM=1, START=2, WAIT=3);
  - a clog2 function;
  - a bitrev(value, width) function.
- One sub-module, fft_frame_timer: the TIMEOUT counter with clear, enable and expire outputs.
- The FSM and write datapath stay in fft_frame_loader.

Test Plan (N=8, ADDR_W=3, TIMEOUT=50 unless noted):
- Natural order: after reset, 16 bytes 0x01..0x10 with 20-clock gaps -> 8 writes at addr 0..7; (re,im) = (01,02),(03,04)..(0F,10); fft_start one pulse exactly 1 cycle after the 8th wr_en; busy=1.
- Bit-reversed order (BITREV=1): same stimulus -> write addresses 0,4,2,6,1,5,3,7 with the same data order.
- Timeout: 5 bytes, then 50 idle clocks -> frame_err pulse on the 50th idle clock; exactly 2 wr_en seen; the next 16 bytes write starting at addr 0; no fft_start until the full frame completes.
- Overrun: full frame, then bytes 0x7F,0x80 before fft_done -> no wr_en, overrun=1 and held through fft_done; ovr_clr -> 0. A frame after fft_done loads normally.
- Reset mid-operation: assert rst after 3 samples, and separately during WAIT -> all outputs 0 immediately; the next frame writes from addr 0; a stale fft_done has no effect.
- Ignored fft_done: fft_done during LOAD_IM -> no state change; the frame completes with 8 writes and one fft_start.
